wb_arbiter: RTL and testbench



---
 rtl/pipeline_pkg.sv | 30 +++
 rtl/rr_arbiter.sv | 39 +++
 rtl/wb_arbiter.sv | 156 +++++++++++++++
 tb/tb_wb_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared execute/writeback pipeline types: writeback request record, FU slot
// indices and the writeback FU-id width for the default four-unit build.
// Used by wb_arbiter; the WB_ARB_LS_PRIORITY_EN option keys on FU_SLS.
package pipeline_pkg;

  // Functional-unit slot assignment on the writeback arbiter request vector
  localparam int FU_SALU = 0;
  localparam int FU_SLS  = 1;
  localparam int FU_BR   = 2;
  localparam int FU_MLS  = 3;

  // Default writeback geometry
  localparam int WB_NUM_FU  = 4;
  localparam int WB_REG_W   = 5;
  localparam int WB_DATA_W  = 32;
  localparam int WB_FU_ID_W = $clog2(WB_NUM_FU);

  // One writeback request as handed from an FU into its holding register
  typedef struct packed {
    logic [WB_REG_W-1:0]  rd;
    logic [WB_DATA_W-1:0] data;
    logic                 spec;
  } wb_req_t;

  // Round-robin successor of idx in a ring of n slots
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set req bit at or above ptr, wrapping modulo N.
// Latency: purely combinational.
// Backpressure: none here; the caller decides whether a grant takes effect.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] winner,
  output logic          found
);

  logic [IW:0]   sum;
  logic [IW-1:0] idx;

  // Walk the ring starting at ptr and latch the first requester seen
  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(N)) begin
        sum = sum - (IW+1)'(N);
      end
      idx = sum[IW-1:0];
      if (!found && req[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        winner      = idx;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Shares the scalar writeback port among execute FUs via one-deep holds + RR arbitration.
// Latency: FU handshake in cycle t gives wb_valid in cycle t+2; one result per cycle.
// Backpressure: wb_ready low freezes wb_*; a hold only refills when empty or being granted.
// Option WB_ARB_LS_PRIORITY_EN: scalar load/store (FU_SLS) pre-empts round-robin.
module wb_arbiter
  import pipeline_pkg::*;
#(
  parameter int NUM_FU = 4,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic                       CLK,
  input  logic                       rst,
  input  logic [NUM_FU-1:0]          fu_valid,
  output logic [NUM_FU-1:0]          fu_ready,
  input  logic [NUM_FU*REG_W-1:0]    fu_rd,
  input  logic [NUM_FU*DATA_W-1:0]   fu_data,
  input  logic [NUM_FU-1:0]          fu_spec,
  input  logic                       flush,
  input  logic                       wb_ready,
  output logic                       wb_valid,
  output logic [REG_W-1:0]           wb_rd,
  output logic [DATA_W-1:0]          wb_data,
  output logic [$clog2(NUM_FU)-1:0]  wb_fu_id,
  output logic                       wb_spec
);

  localparam int IDW = $clog2(NUM_FU);

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic              spec;
    logic [DATA_W-1:0] data;
  } hold_t;

  hold_t             hold_q [NUM_FU];
  logic [NUM_FU-1:0] hold_v;
  logic [IDW-1:0]    rr_ptr;

  logic              out_free;
  logic [NUM_FU-1:0] rr_grant;
  logic [IDW-1:0]    rr_winner;
  logic              rr_found;
  logic [NUM_FU-1:0] grant;
  logic [IDW-1:0]    winner;
  logic              arb_found;
  logic              ls_win;
  logic              eff_grant;
  logic [NUM_FU-1:0] store;
  hold_t             win_q;

  // The output slot can take a new entry when empty or being drained this cycle
  assign out_free  = !wb_valid || wb_ready;
  assign eff_grant = arb_found && out_free;
  assign win_q     = hold_q[winner];

  rr_arbiter #(
    .N  (NUM_FU),
    .IW (IDW)
  ) u_rr (
    .req    (hold_v),
    .ptr    (rr_ptr),
    .grant  (rr_grant),
    .winner (rr_winner),
    .found  (rr_found)
  );

`ifdef WB_ARB_LS_PRIORITY_EN
  // Scalar load/store wins outright whenever it holds a result; others stay RR
  always_comb begin
    ls_win    = hold_v[FU_SLS];
    grant     = rr_grant;
    winner    = rr_winner;
    arb_found = rr_found;
    if (ls_win) begin
      grant         = '0;
      grant[FU_SLS] = 1'b1;
      winner        = IDW'(FU_SLS);
      arb_found     = 1'b1;
    end
  end
`else
  // Pure round-robin over every FU
  always_comb begin
    ls_win    = 1'b0;
    grant     = rr_grant;
    winner    = rr_winner;
    arb_found = rr_found;
  end
`endif

  // Ready when the hold is empty or its entry leaves for the output this cycle;
  // store filters out rd==0 and results killed by a same-cycle flush
  always_comb begin
    fu_ready = '0;
    store    = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      fu_ready[i] = !rst && (!hold_v[i] || (grant[i] && out_free));
      store[i]    = fu_valid[i] && fu_ready[i] &&
                    (fu_rd[i*REG_W +: REG_W] != '0) &&
                    !(fu_spec[i] && flush);
    end
  end

  // Holding registers: refill wins over drain; flush kills speculative entries
  always_ff @(posedge CLK) begin
    if (rst) begin
      hold_v <= '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (store[i]) begin
          hold_v[i]      <= 1'b1;
          hold_q[i].rd   <= fu_rd[i*REG_W +: REG_W];
          hold_q[i].data <= fu_data[i*DATA_W +: DATA_W];
          hold_q[i].spec <= fu_spec[i];
        end else if ((grant[i] && eff_grant) || (flush && hold_q[i].spec)) begin
          hold_v[i] <= 1'b0;
        end
      end
    end
  end

  // Round-robin pointer moves past the winner; an LS priority win leaves it alone
  always_ff @(posedge CLK) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (eff_grant && !ls_win) begin
      rr_ptr <= IDW'(rr_next(int'(winner), NUM_FU));
    end
  end

  // Output register: load winner when free, freeze when stalled, drop spec on flush
  always_ff @(posedge CLK) begin
    if (rst) begin
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
      wb_fu_id <= '0;
      wb_spec  <= 1'b0;
    end else if (out_free) begin
      if (eff_grant) begin
        // A speculative winner caught by flush is consumed but never presented
        wb_valid <= !(flush && win_q.spec);
        wb_rd    <= win_q.rd;
        wb_data  <= win_q.data;
        wb_spec  <= win_q.spec;
        wb_fu_id <= winner;
      end else begin
        wb_valid <= 1'b0;
      end
    end else if (flush && wb_spec) begin
      wb_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with per-FU expected-result queues.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
// Honours WB_ARB_LS_PRIORITY_EN when it is defined for the build.
module tb_wb_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int RW = 5;

  logic            CLK = 1'b0;
  logic            rst;
  logic [N-1:0]    fu_valid;
  logic [N-1:0]    fu_ready;
  logic [N*RW-1:0] fu_rd;
  logic [N*DW-1:0] fu_data;
  logic [N-1:0]    fu_spec;
  logic            flush;
  logic            wb_ready;
  logic            wb_valid;
  logic [RW-1:0]   wb_rd;
  logic [DW-1:0]   wb_data;
  logic [1:0]      wb_fu_id;
  logic            wb_spec;

  int n_assert = 0;
  int n_fail   = 0;

  logic [RW+DW-1:0] expq [N][$];
  int               id_log[$];
  logic [15:0]      seq [N];

  wb_arbiter #(.NUM_FU(N), .DATA_W(DW), .REG_W(RW)) dut (
    .CLK      (CLK),
    .rst      (rst),
    .fu_valid (fu_valid),
    .fu_ready (fu_ready),
    .fu_rd    (fu_rd),
    .fu_data  (fu_data),
    .fu_spec  (fu_spec),
    .flush    (flush),
    .wb_ready (wb_ready),
    .wb_valid (wb_valid),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .wb_fu_id (wb_fu_id),
    .wb_spec  (wb_spec)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_fu(input int i, input logic v, input logic [RW-1:0] rd,
                        input logic [DW-1:0] d, input logic s);
    fu_valid[i]          = v;
    fu_rd[i*RW +: RW]    = rd;
    fu_data[i*DW +: DW]  = d;
    fu_spec[i]           = s;
  endtask

  function automatic logic [DW-1:0] mk_data(input int i);
    return {8'(i), 8'h00, seq[i]};
  endfunction

  function automatic int qtotal();
    int t = 0;
    for (int i = 0; i < N; i++) t += expq[i].size();
    return t;
  endfunction

  // Every accepted writeback must match the oldest outstanding result of its FU
  always @(negedge CLK) begin
    if (!rst && wb_valid && wb_ready) begin
      id_log.push_back(int'(wb_fu_id));
      check("output_expected", 64'(expq[wb_fu_id].size() != 0), 64'd1);
      if (expq[wb_fu_id].size() != 0) begin
        check("wb_rd_data", 64'({wb_rd, wb_data}), 64'(expq[wb_fu_id].pop_front()));
      end
    end
  end

  // Drive all FUs in mask continuously for ncyc cycles, fresh data after each handshake
  task automatic stream(input logic [N-1:0] mask, input int ncyc);
    logic [N-1:0] acc;
    nxt();
    for (int i = 0; i < N; i++)
      if (mask[i]) set_fu(i, 1'b1, RW'(i + 1), mk_data(i), 1'b0);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge CLK);
      acc = fu_valid & fu_ready;
      for (int i = 0; i < N; i++)
        if (acc[i]) expq[i].push_back({RW'(i + 1), mk_data(i)});
      nxt();
      for (int i = 0; i < N; i++) begin
        if (c == ncyc - 1) begin
          fu_valid[i] = 1'b0;
        end else if (acc[i]) begin
          seq[i]++;
          fu_data[i*DW +: DW] = mk_data(i);
        end
      end
    end
  endtask

  // Wait (bounded) for every expected result to appear and the output to empty
  task automatic drain(input string tag);
    for (int k = 0; k < 60; k++) begin
      @(negedge CLK);
      if (!wb_valid && qtotal() == 0) break;
    end
    check({tag, "_queues_empty"}, 64'(qtotal()), 64'd0);
    check({tag, "_wb_idle"}, 64'(wb_valid), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] acc;
    logic [RW+DW+4-1:0] snap;

    rst = 1'b1; fu_valid = '0; fu_rd = '0; fu_data = '0; fu_spec = '0;
    flush = 1'b0; wb_ready = 1'b1;
    for (int i = 0; i < N; i++) seq[i] = '0;

    // Reset state
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_fu_ready", 64'(fu_ready), 64'd0);
    check("rst_wb_valid", 64'(wb_valid), 64'd0);
    check("rst_wb_rd",    64'(wb_rd),    64'd0);
    check("rst_wb_data",  64'(wb_data),  64'd0);
    check("rst_wb_fu_id", 64'(wb_fu_id), 64'd0);
    check("rst_wb_spec",  64'(wb_spec),  64'd0);
    nxt(); rst = 1'b0;
    @(negedge CLK);
    check("post_rst_ready", 64'(fu_ready), 64'hF);

    // Single request: FU0 rd=3, visible two cycles after the handshake, for one cycle
    nxt();
    set_fu(0, 1'b1, 5'd3, 32'hDEAD_BEEF, 1'b0);
    expq[0].push_back({5'd3, 32'hDEAD_BEEF});
    @(negedge CLK);
    check("single_ready", 64'(fu_ready[0]), 64'd1);
    nxt();
    set_fu(0, 1'b0, 5'd0, 32'h0, 1'b0);
    @(negedge CLK);
    check("single_t1_valid", 64'(wb_valid), 64'd0);
    @(negedge CLK);
    check("single_t2_valid", 64'(wb_valid), 64'd1);
    check("single_t2_rd",    64'(wb_rd),    64'd3);
    check("single_t2_data",  64'(wb_data),  64'hDEAD_BEEF);
    check("single_t2_fu_id", 64'(wb_fu_id), 64'd0);
    @(negedge CLK);
    check("single_t3_valid", 64'(wb_valid), 64'd0);

    // Fairness: all four FUs stream; pointer sits at 1 after the single FU0 grant
    id_log.delete();
    stream(4'hF, 16);
    drain("fair");
    check("fair_count", 64'(id_log.size() >= 12), 64'd1);
    for (int k = 0; k < 12 && k < id_log.size(); k++) begin
`ifdef WB_ARB_LS_PRIORITY_EN
      check("fair_ls_id", 64'(id_log[k]), 64'd1);
`else
      check("fair_rr_id", 64'(id_log[k]), 64'((1 + k) % 4));
`endif
    end

    // Backpressure: fill every hold plus the output with wb_ready low
    nxt();
    wb_ready = 1'b0;
    for (int i = 0; i < N; i++) set_fu(i, 1'b1, RW'(i + 1), mk_data(i), 1'b0);
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      acc = fu_valid & fu_ready;
      for (int i = 0; i < N; i++)
        if (acc[i]) expq[i].push_back({RW'(i + 1), mk_data(i)});
      if (fu_ready == '0) break;
      nxt();
      for (int i = 0; i < N; i++)
        if (acc[i]) begin seq[i]++; fu_data[i*DW +: DW] = mk_data(i); end
    end
    check("bp_queued", 64'(qtotal()), 64'd5);
    nxt();
    fu_valid = '0;
    @(negedge CLK);
    snap = {wb_valid, wb_rd, wb_data, wb_fu_id, wb_spec};
    check("bp_wb_valid", 64'(wb_valid), 64'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      check("bp_stable", 64'({wb_valid, wb_rd, wb_data, wb_fu_id, wb_spec}), 64'(snap));
      check("bp_full_ready", 64'(fu_ready), 64'd0);
    end
    nxt();
    wb_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      check("bp_burst_valid", 64'(wb_valid), 64'd1);
    end
    @(negedge CLK);
    check("bp_burst_end", 64'(wb_valid), 64'd0);
    check("bp_all_delivered", 64'(qtotal()), 64'd0);

    // Flush: output holds FU1 spec, FU2 holds spec, FU0 holds non-spec
    nxt();
    wb_ready = 1'b0;
    set_fu(1, 1'b1, 5'd9, 32'h1111_1111, 1'b1);
    @(negedge CLK);
    check("flush_fu1_ready", 64'(fu_ready[1]), 64'd1);
    nxt();
    set_fu(1, 1'b0, 5'd0, 32'h0, 1'b0);
    set_fu(2, 1'b1, 5'd10, 32'h2222_2222, 1'b1);
    set_fu(0, 1'b1, 5'd11, 32'h0B0B_0B0B, 1'b0);
    expq[0].push_back({5'd11, 32'h0B0B_0B0B});
    @(negedge CLK);
    check("flush_fu02_ready", 64'({fu_ready[2], fu_ready[0]}), 64'b11);
    nxt();
    set_fu(2, 1'b0, 5'd0, 32'h0, 1'b0);
    set_fu(0, 1'b0, 5'd0, 32'h0, 1'b0);
    flush = 1'b1;
    @(negedge CLK);
    check("flush_pre_out", 64'({wb_valid, wb_spec, wb_fu_id}), 64'b1101);
    nxt();
    flush = 1'b0;
    wb_ready = 1'b1;
    @(negedge CLK);
    check("flush_out_dropped", 64'(wb_valid), 64'd0);
    @(negedge CLK);
    check("flush_fu0_out", 64'({wb_valid, wb_fu_id, wb_rd}), 64'({1'b1, 2'd0, 5'd11}));
    drain("flush");

    // rd=0 is accepted but never written back
    nxt();
    set_fu(3, 1'b1, 5'd0, 32'h3333_3333, 1'b0);
    @(negedge CLK);
    check("rd0_ready", 64'(fu_ready[3]), 64'd1);
    nxt();
    set_fu(3, 1'b0, 5'd0, 32'h0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      check("rd0_no_wb", 64'(wb_valid), 64'd0);
    end

    // FU0 vs FU1 streaming; pointer is 1 after the flush test's FU0 grant
    id_log.delete();
    stream(4'b0011, 12);
    drain("ls");
    check("ls_count", 64'(id_log.size() >= 8), 64'd1);
    for (int k = 0; k < 8 && k < id_log.size(); k++) begin
`ifdef WB_ARB_LS_PRIORITY_EN
      check("ls_prio_id", 64'(id_log[k]), 64'd1);
`else
      check("ls_alt_id", 64'(id_log[k]), 64'((k % 2 == 0) ? 1 : 0));
`endif
    end

    // Reset while holds are full discards everything
    nxt();
    wb_ready = 1'b0;
    for (int i = 0; i < N; i++) set_fu(i, 1'b1, 5'd7, 32'h7777_0000, 1'b0);
    @(negedge CLK);
    nxt();
    fu_valid = '0;
    rst = 1'b1;
    @(negedge CLK);
    check("midrst_ready", 64'(fu_ready), 64'd0);
    nxt();
    rst = 1'b0;
    wb_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      check("midrst_no_wb", 64'(wb_valid), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
